sync_frame_tx: RTL and testbench

//  Serial frame transmitter: accepts a parallel payload word via a ready/start handshake and emits
//  it bit-serially as SYNC word, then payload MSB-first, then an idle gap. The default SYNC of 1010
//  is the pattern our serial sequence detectors lock onto, so this block drives their input line.
//  It sits between a parallel producer and a one-bit serial link.

---
 rtl/sync_frame_pkg.sv | 21 ++
 rtl/piso_shift_reg.sv | 49 ++++
 rtl/sync_frame_tx.sv | 152 +++++++++++++++
 tb/tb_sync_frame_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_frame_pkg.sv
// Shared definitions for the sync-framed serial link, used by the transmitter and the matching receiver.
package sync_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int                    SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_DEF   = 4'b1010;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: parallel load, shift left, MSB presented first.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic         msb,
    output logic         next_msb
);

    logic [W-1:0] sr_d;
    logic [W-1:0] sr_q;

    // Next shift-register contents; load has priority over shift.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift_en) begin
            sr_d = sr_q << 1;
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift-register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[W-1];

    // The bit that becomes the MSB after the next shift.
    generate
        if (W > 1) begin : g_wide
            assign next_msb = sr_q[W-2];
        end else begin : g_single
            assign next_msb = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: SYNC word, payload MSB-first, then an idle gap on a registered line.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC     = SYNC_DEF,
    parameter int                GAP      = 2,
    parameter logic              IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              o,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              o_d, o_q;
    logic              ready_d, ready_q;
    logic              busy_d, busy_q;
    logic              frame_done_d, frame_done_q;
    logic              load_s, shift_s;
    logic              sr_msb_s, sr_next_msb_s;
    logic [SYNC_W-1:0] sync_sh_s;

    piso_shift_reg #(.W(DATA_W)) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .shift_en (shift_s),
        .din      (data_in),
        .msb      (sr_msb_s),
        .next_msb (sr_next_msb_s)
    );

    // Next state and down-counter; each phase ends when the counter reaches zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SYNC;
                    cnt_d   = SYNC_LAST;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LAST;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                shift_s = 1'b1;
                if (cnt_q == '0) begin
                    frame_done_d = 1'b1;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LAST;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The counter indexes the SYNC bit directly: SYNC_W-1 down to 0 gives MSB-first order.
    assign sync_sh_s = SYNC >> cnt_d;

    // Line level and status for the coming cycle, decoded from the next state.
    always_comb begin
        o_d = IDLE_BIT;
        case (state_d)
            ST_SYNC: begin
                o_d = sync_sh_s[0];
            end
            ST_DATA: begin
                if (state_q == ST_DATA) begin
                    o_d = sr_next_msb_s;
                end else begin
                    o_d = sr_msb_s;
                end
            end
            default: begin
                o_d = IDLE_BIT;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            o_q          <= IDLE_BIT;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_q          <= o_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o          = o_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed-vector bench for sync_frame_tx: default build plus a SYNC_W=1/DATA_W=1/GAP=0 build.
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       ready, o, busy, frame_done;

    logic       t_start;
    logic [0:0] t_data;
    logic       t_ready, t_o, t_busy, t_done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sync_frame_tx #(
        .DATA_W(8), .SYNC_W(4), .SYNC(4'b1010), .GAP(2), .IDLE_BIT(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .ready(ready), .o(o), .busy(busy), .frame_done(frame_done)
    );

    sync_frame_tx #(
        .DATA_W(1), .SYNC_W(1), .SYNC(1'b1), .GAP(0), .IDLE_BIT(1'b0)
    ) u_tiny (
        .clk(clk), .rst(rst), .start(t_start), .data_in(t_data),
        .ready(t_ready), .o(t_o), .busy(t_busy), .frame_done(t_done)
    );

    // Overlapping Moore 1010 detector fed by the serial line; y is high in state 4.
    logic [2:0] det_q;
    logic       det_y;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_q <= 3'd0;
        end else begin
            case (det_q)
                3'd0:    det_q <= o ? 3'd1 : 3'd0;
                3'd1:    det_q <= o ? 3'd1 : 3'd2;
                3'd2:    det_q <= o ? 3'd3 : 3'd0;
                3'd3:    det_q <= o ? 3'd1 : 3'd4;
                3'd4:    det_q <= o ? 3'd3 : 3'd0;
                default: det_q <= 3'd0;
            endcase
        end
    end
    assign det_y = (det_q == 3'd4);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_in = 8'h3C; t_start = 1'b1; t_data = 1'b1;
        step();
        tests_run++;
        if ({o, ready, busy, frame_done} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL reset_hold got=%b exp=0100", {o, ready, busy, frame_done});
        end
        repeat (3) step();
        tests_run++;
        if ({busy, t_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_beats_start got=%b exp=00", {busy, t_busy});
        end
        start = 1'b0; t_start = 1'b0;
        #2;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            tests_run++;
            if ({o, ready, busy, frame_done, t_o, t_ready, t_busy, t_done} !== 8'b0100_0100) begin
                tests_failed++;
                $display("FAIL idle_after_reset cyc=%0d got=%b exp=01000100", c,
                         {o, ready, busy, frame_done, t_o, t_ready, t_busy, t_done});
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [13:0] exp_bits;
        exp_bits = 14'b1010_1010_0101_00;
        data_in = 8'hA5; start = 1'b1;
        step();
        start = 1'b0; data_in = 8'h00;
        for (int k = 0; k < 14; k++) begin
            tests_run++;
            if (o !== exp_bits[13-k] || {ready, busy} !== 2'b01 || frame_done !== (k == 12)) begin
                tests_failed++;
                $display("FAIL a5_frame k=%0d got o=%b rdy=%b busy=%b done=%b exp o=%b rdy=0 busy=1 done=%b",
                         k, o, ready, busy, frame_done, exp_bits[13-k], (k == 12));
            end
            step();
        end
        tests_run++;
        if ({o, ready, busy, frame_done} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL a5_ready_back got=%b exp=0100", {o, ready, busy, frame_done});
        end
    endtask

    task automatic test_detector();
        int pulses;
        pulses = 0;
        repeat (3) step();
        data_in = 8'h0F; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (det_y !== (k == 4)) begin
                tests_failed++;
                $display("FAIL det_y k=%0d got=%b exp=%b", k, det_y, (k == 4));
            end
            if (det_y === 1'b1) pulses++;
            step();
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL det_pulse_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] exp_bits;
        exp_bits = 29'b1010_0000_0001_000_1010_1000_0000_00;
        data_in = 8'h01; start = 1'b1;
        step();
        for (int c = 1; c <= 29; c++) begin
            tests_run++;
            if (o !== exp_bits[29-c]) begin
                tests_failed++;
                $display("FAIL b2b_o cyc=%0d got=%b exp=%b", c, o, exp_bits[29-c]);
            end
            if (c == 15) begin
                tests_run++;
                if (ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_idle_ready got=%b exp=1", ready);
                end
            end
            if (c == 2) data_in = 8'h80;
            if (c == 16) start = 1'b0;
            step();
        end
        tests_run++;
        if ({o, ready, busy} !== 3'b010) begin
            tests_failed++;
            $display("FAIL b2b_end got=%b exp=010", {o, ready, busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] exp_bits;
        int          done_seen;
        data_in = 8'h3C; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        tests_run++;
        if ({o, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL mid_pre_reset got=%b exp=11", {o, busy});
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({o, ready, busy, frame_done} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL mid_async_reset got=%b exp=0100", {o, ready, busy, frame_done});
        end
        step();
        #2;
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (frame_done === 1'b1 || ready !== 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL mid_no_done got=%0d bad cycles exp=0", done_seen);
        end
        exp_bits = 14'b1010_1111_1111_00;
        data_in = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tests_run++;
            if (k < 14) begin
                if (o !== exp_bits[13-k] || frame_done !== (k == 12)) begin
                    tests_failed++;
                    $display("FAIL ff_frame k=%0d got o=%b done=%b exp o=%b done=%b",
                             k, o, frame_done, exp_bits[13-k], (k == 12));
                end
            end else begin
                if ({o, ready, busy} !== 3'b010) begin
                    tests_failed++;
                    $display("FAIL ff_end got=%b exp=010", {o, ready, busy});
                end
            end
            step();
        end
    endtask

    task automatic test_tiny();
        logic [3:0] exp_v [4];
        exp_v[0] = 4'b1010;
        exp_v[1] = 4'b1010;
        exp_v[2] = 4'b0101;
        exp_v[3] = 4'b0100;
        t_data = 1'b1; t_start = 1'b1;
        step();
        t_start = 1'b0; t_data = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if ({t_o, t_ready, t_busy, t_done} !== exp_v[k]) begin
                tests_failed++;
                $display("FAIL tiny_frame k=%0d got=%b exp=%b", k, {t_o, t_ready, t_busy, t_done}, exp_v[k]);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = 8'h00; t_start = 1'b0; t_data = 1'b0;
        test_reset();
        test_frame_a5();
        test_detector();
        test_back_to_back();
        test_reset_mid();
        test_tiny();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
